// File: rtl/cam_match_scanner.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_scanner
// Purpose  : Captures a 32-bit CAM match-line vector, presents it to an
//            external 32:1 mux and walks the mux select from 0 upward,
//            using the returned mux bit to count matches and find the
//            lowest matching entry. Also cross-checks the returned bit
//            against the captured vector and flags any disagreement.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STOP_ON_FIRST  1: end the scan at the first returned match
//                  0: always walk all 32 lines
// Ports
//   clk_i          rising-edge clock for all state
//   reset_i        synchronous, active-high reset
//   start_i        capture match_lines_i and begin a scan (IDLE only)
//   match_lines_i  CAM match-line vector, bit i = entry i matched
//   mux_out_i      single-bit result from the external 32:1 mux
//   mux_lines_o    captured match vector, drives the mux data inputs
//   mux_sel_o      mux select, equals the index under test while scanning
//   busy_o         high while scanning
//   done_o         one-cycle pulse when a scan completes
//   hit_o          at least one match seen in the last scan
//   hit_index_o    lowest matching index seen
//   hit_count_o    number of matches seen (0..32)
//   mux_err_o      sticky: mux_out_i disagreed with mux_lines_o[mux_sel_o]
// ============================================================================
module cam_match_scanner #(
    parameter logic STOP_ON_FIRST = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] match_lines_i,
    input  logic        mux_out_i,
    output logic [31:0] mux_lines_o,
    output logic [4:0]  mux_sel_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        hit_o,
    output logic [4:0]  hit_index_o,
    output logic [5:0]  hit_count_o,
    output logic        mux_err_o
);

    localparam logic [4:0] c_LAST_SEL = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] mux_lines_q, mux_lines_d;
    logic [4:0]  mux_sel_q,   mux_sel_d;
    logic        hit_q,       hit_d;
    logic [4:0]  hit_index_q, hit_index_d;
    logic [5:0]  hit_count_q, hit_count_d;
    logic        mux_err_q,   mux_err_d;

    // Bit the mux ought to be returning for the current select.
    logic        w_expected_bit;
    logic        w_last_line;
    logic        w_early_stop;

    assign w_expected_bit = mux_lines_q[mux_sel_q];
    assign w_last_line    = (mux_sel_q == c_LAST_SEL);
    assign w_early_stop   = STOP_ON_FIRST && mux_out_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mux_lines_q <= 32'd0;
            mux_sel_q   <= 5'd0;
            hit_q       <= 1'b0;
            hit_index_q <= 5'd0;
            hit_count_q <= 6'd0;
            mux_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_lines_q <= mux_lines_d;
            mux_sel_q   <= mux_sel_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
            hit_count_q <= hit_count_d;
            mux_err_q   <= mux_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Result registers hold by default so they remain
    // readable through DONE and IDLE until the next accepted start.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mux_lines_d = mux_lines_q;
        mux_sel_d   = mux_sel_q;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        hit_count_d = hit_count_q;
        mux_err_d   = mux_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mux_lines_d = match_lines_i;
                    mux_sel_d   = 5'd0;
                    hit_d       = 1'b0;
                    hit_index_d = 5'd0;
                    hit_count_d = 6'd0;
                    mux_err_d   = 1'b0;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Hit bookkeeping trusts the mux result even when it
                // disagrees with the captured vector; the disagreement is
                // reported separately through the error flag.
                if (mux_out_i) begin
                    hit_count_d = hit_count_q + 6'd1;
                    hit_d       = 1'b1;
                    if (!hit_q) begin
                        hit_index_d = mux_sel_q;
                    end
                end

                if (mux_out_i != w_expected_bit) begin
                    mux_err_d = 1'b1;
                end

                // Exit at the last line wins over the increment, so the
                // select never wraps back to zero.
                if (w_last_line || w_early_stop) begin
                    state_d = ST_DONE;
                end else begin
                    mux_sel_d = mux_sel_q + 5'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy_o      = (state_q == ST_SCAN);
    assign done_o      = (state_q == ST_DONE);
    assign mux_lines_o = mux_lines_q;
    assign mux_sel_o   = mux_sel_q;
    assign hit_o       = hit_q;
    assign hit_index_o = hit_index_q;
    assign hit_count_o = hit_count_q;
    assign mux_err_o   = mux_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_match_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_match_scanner
// Purpose  : Directed bench for cam_match_scanner. Two instances share the
//            clock, reset and match-line input: u_dut0 scans all lines,
//            u_dut1 stops on the first match. Each instance is fed by a
//            behavioural 32:1 mux; the mux of u_dut0 can be made to
//            return the wrong bit at select 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_match_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0;
    logic        start1;
    logic [31:0] match_lines;
    logic        inject;
    logic        mux_out0;
    logic        mux_out1;

    logic [31:0] lines0, lines1;
    logic [4:0]  sel0, sel1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic        hit0, hit1;
    logic [4:0]  idx0, idx1;
    logic [5:0]  cnt0, cnt1;
    logic        err0, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External 32:1 mux models.
    assign mux_out0 = lines0[sel0] ^ (inject && (sel0 == 5'd5));
    assign mux_out1 = lines1[sel1];

    cam_match_scanner #(.STOP_ON_FIRST(1'b0)) u_dut0 (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start0),
        .match_lines_i (match_lines),
        .mux_out_i     (mux_out0),
        .mux_lines_o   (lines0),
        .mux_sel_o     (sel0),
        .busy_o        (busy0),
        .done_o        (done0),
        .hit_o         (hit0),
        .hit_index_o   (idx0),
        .hit_count_o   (cnt0),
        .mux_err_o     (err0)
    );

    cam_match_scanner #(.STOP_ON_FIRST(1'b1)) u_dut1 (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start1),
        .match_lines_i (match_lines),
        .mux_out_i     (mux_out1),
        .mux_lines_o   (lines1),
        .mux_sel_o     (sel1),
        .busy_o        (busy1),
        .done_o        (done1),
        .hit_o         (hit1),
        .hit_index_o   (idx1),
        .hit_count_o   (cnt1),
        .mux_err_o     (err1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        logic [51:0] all0;
        logic [51:0] all1;
        reset       = 1'b1;
        start0      = 1'b0;
        start1      = 1'b0;
        inject      = 1'b0;
        match_lines = 32'hDEADBEEF;
        tick;
        tick;
        reset = 1'b0;
        all0 = {lines0, sel0, busy0, done0, hit0, idx0, cnt0, err0};
        all1 = {lines1, sel1, busy1, done1, hit1, idx1, cnt1, err1};
        total++;
        if (all0 !== 52'd0) begin
            bad++;
            $display("FAIL reset_outputs_dut0: got %h want 0", all0);
        end
        total++;
        if (all1 !== 52'd0) begin
            bad++;
            $display("FAIL reset_outputs_dut1: got %h want 0", all1);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if ({busy0, done0, busy1, done1} !== 4'b0000) begin
                bad++;
                $display("FAIL idle_quiet cycle %0d: got busy/done %b want 0000",
                         i, {busy0, done0, busy1, done1});
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_full_scan_empty;
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        match_lines = 32'h0000_0000;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            if (busy0) n++;
            tick;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL empty_done_seen: got 0 want 1");
        end
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL empty_busy_cycles: got %0d want 32", n);
        end
        total++;
        if ({busy0, hit0, idx0, cnt0, err0} !== 14'd0) begin
            bad++;
            $display("FAIL empty_result: got busy=%b hit=%b idx=%0d cnt=%0d err=%b want all 0",
                     busy0, hit0, idx0, cnt0, err0);
        end
        tick;
        total++;
        if ({busy0, done0} !== 2'b00) begin
            bad++;
            $display("FAIL empty_back_idle: got busy/done %b want 00", {busy0, done0});
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_two_hits_start_held;
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        match_lines = 32'h8000_0001;
        start0 = 1'b1;
        tick;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            if (busy0) n++;
            tick;
        end
        total++;
        if (!seen || n != 32) begin
            bad++;
            $display("FAIL held_busy_cycles: got seen=%0d n=%0d want seen=1 n=32", seen, n);
        end
        total++;
        if ({hit0, idx0, cnt0, err0} !== {1'b1, 5'd0, 6'd2, 1'b0}) begin
            bad++;
            $display("FAIL two_hits_result: got hit=%b idx=%0d cnt=%0d err=%b want 1/0/2/0",
                     hit0, idx0, cnt0, err0);
        end
        // DONE -> IDLE edge: held start must not be taken here.
        tick;
        total++;
        if ({busy0, done0, hit0} !== 3'b001) begin
            bad++;
            $display("FAIL held_ignored_in_done: got busy/done/hit %b want 001",
                     {busy0, done0, hit0});
        end
        // First IDLE edge accepts the held start and clears the results.
        tick;
        total++;
        if ({busy0, hit0, cnt0} !== {1'b1, 1'b0, 6'd0}) begin
            bad++;
            $display("FAIL held_accept_in_idle: got busy=%b hit=%b cnt=%0d want 1/0/0",
                     busy0, hit0, cnt0);
        end
        start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        total++;
        if (!seen || cnt0 !== 6'd2) begin
            bad++;
            $display("FAIL second_scan: got seen=%0d cnt=%0d want seen=1 cnt=2", seen, cnt0);
        end
        tick;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stop_on_first;
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        match_lines = 32'h0000_0100;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            if (busy1) n++;
            if (i == 3) match_lines = 32'hFFFF_FFFF;
            tick;
        end
        total++;
        if (!seen || n != 9) begin
            bad++;
            $display("FAIL stop_busy_cycles: got seen=%0d n=%0d want seen=1 n=9", seen, n);
        end
        total++;
        if ({hit1, idx1, cnt1, err1, sel1} !== {1'b1, 5'd8, 6'd1, 1'b0, 5'd8}) begin
            bad++;
            $display("FAIL stop_result: got hit=%b idx=%0d cnt=%0d err=%b sel=%0d want 1/8/1/0/8",
                     hit1, idx1, cnt1, err1, sel1);
        end
        total++;
        if (lines1 !== 32'h0000_0100) begin
            bad++;
            $display("FAIL stop_capture: got %h want 00000100", lines1);
        end
        tick;
        total++;
        if ({done1, busy1, sel1, idx1} !== {1'b0, 1'b0, 5'd8, 5'd8}) begin
            bad++;
            $display("FAIL stop_hold_idle: got done=%b busy=%b sel=%0d idx=%0d want 0/0/8/8",
                     done1, busy1, sel1, idx1);
        end
        match_lines = 32'h0000_0000;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mux_fault;
        bit seen;
        seen = 1'b0;
        inject = 1'b1;
        match_lines = 32'hFFFF_FFFF;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        total++;
        if (!seen || {err0, hit0, idx0, cnt0} !== {1'b1, 1'b1, 5'd0, 6'd31}) begin
            bad++;
            $display("FAIL fault_result: got seen=%0d err=%b hit=%b idx=%0d cnt=%0d want 1/1/1/0/31",
                     seen, err0, hit0, idx0, cnt0);
        end
        tick;
        inject = 1'b0;
        match_lines = 32'h0000_0010;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        total++;
        if ({busy0, err0} !== 2'b10) begin
            bad++;
            $display("FAIL fault_cleared_on_start: got busy/err %b want 10", {busy0, err0});
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        total++;
        if (!seen || {err0, idx0, cnt0} !== {1'b0, 5'd4, 6'd1}) begin
            bad++;
            $display("FAIL clean_rescan: got seen=%0d err=%b idx=%0d cnt=%0d want 1/0/4/1",
                     seen, err0, idx0, cnt0);
        end
        tick;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_scan;
        logic [51:0] all0;
        int n;
        bit seen;
        bit pulsed;
        match_lines = 32'hFFFF_0000;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sel0 == 5'd10) break;
            tick;
        end
        total++;
        if ({busy0, sel0} !== {1'b1, 5'd10}) begin
            bad++;
            $display("FAIL reach_sel10: got busy=%b sel=%0d want 1/10", busy0, sel0);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        all0 = {lines0, sel0, busy0, done0, hit0, idx0, cnt0, err0};
        total++;
        if (all0 !== 52'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", all0);
        end
        pulsed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (done0) pulsed = 1'b1;
        end
        total++;
        if (pulsed) begin
            bad++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        n = 0;
        seen = 1'b0;
        match_lines = 32'h0000_0400;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            if (busy0) n++;
            tick;
        end
        total++;
        if (!seen || n != 32 || {hit0, idx0, cnt0, err0} !== {1'b1, 5'd10, 6'd1, 1'b0}) begin
            bad++;
            $display("FAIL post_abort_scan: got seen=%0d n=%0d hit=%b idx=%0d cnt=%0d err=%b want 1/32/1/10/1/0",
                     seen, n, hit0, idx0, cnt0, err0);
        end
        tick;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset;
        test_full_scan_empty;
        test_two_hits_start_held;
        test_stop_on_first;
        test_mux_fault;
        test_reset_mid_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
